// File: rtl/dma_channel_scheduler_pkg.sv
// Shared types and helpers for the DMA channel scheduler.
package dma_channel_scheduler_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dma_channel_scheduler_if.sv
// Channel-side descriptor bus and engine-side command bus.
interface dma_ch_if #(parameter int NUM_CH = 4, parameter int ADDR_W = 32);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_src;
  logic [NUM_CH*ADDR_W-1:0] ch_dest;
  logic [NUM_CH*ADDR_W-1:0] ch_size;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;

  modport master (output ch_req, ch_src, ch_dest, ch_size, input ch_ack, ch_done, ch_err);
  modport slave  (input ch_req, ch_src, ch_dest, ch_size, output ch_ack, ch_done, ch_err);
endinterface

interface dma_eng_if #(parameter int ADDR_W = 32);
  logic              dma_start;
  logic [ADDR_W-1:0] dma_src;
  logic [ADDR_W-1:0] dma_dest;
  logic [ADDR_W-1:0] dma_size;
  logic              dma_busy;
  logic              dma_done;

  modport master (output dma_start, dma_src, dma_dest, dma_size, input dma_busy, dma_done);
  modport slave  (input dma_start, dma_src, dma_dest, dma_size, output dma_busy, dma_done);
endinterface

// File: rtl/dma_channel_scheduler_rr_arbiter.sv
// Round-robin pick: first pending index strictly after last_grant, wrapping upward.
module dma_rr_arbiter
  import dma_channel_scheduler_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [CH_W-1:0]   last_grant,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_idx
);

  // Scan farthest-first so the nearest pending channel after last_grant overwrites last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (pend[(int'(last_grant) + k) % NUM_CH]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'((int'(last_grant) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Latches per-channel descriptors and time-shares one DMA engine round-robin.
module dma_channel_scheduler
  import dma_channel_scheduler_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int ADDR_W      = ADDR_W_DEF,
  parameter  int TIMEOUT_CYC = 64,
  localparam int CH_W        = clog2(NUM_CH),
  localparam int CNT_W       = clog2(TIMEOUT_CYC + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  dma_ch_if.slave         ch,
  dma_eng_if.master       eng,
  output logic            sched_busy,
  output logic [CH_W-1:0] active_ch
);

  state_t                         state;
  logic [NUM_CH-1:0]              pend;
  logic [NUM_CH-1:0]              ack_q;
  logic [NUM_CH-1:0]              cap;
  logic [NUM_CH-1:0][ADDR_W-1:0]  src_r, dest_r, size_r;
  logic [CH_W-1:0]                last_grant;
  logic [CNT_W-1:0]               cnt;
  logic                           err_flag;
  logic                           grant_valid;
  logic [CH_W-1:0]                grant_idx;
  logic [NUM_CH-1:0]              act_oh;

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pend        (pend),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The ack guard keeps a still-high req from re-capturing in the cycle it is being dropped.
  assign cap = ch.ch_req & ~pend & ~ack_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      pend         <= '0;
      ack_q        <= '0;
      src_r        <= '0;
      dest_r       <= '0;
      size_r       <= '0;
      last_grant   <= CH_W'(NUM_CH - 1);
      cnt          <= '0;
      err_flag     <= 1'b0;
      active_ch    <= '0;
      eng.dma_src  <= '0;
      eng.dma_dest <= '0;
      eng.dma_size <= '0;
    end else begin
      ack_q <= cap;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          pend[i]   <= 1'b1;
          src_r[i]  <= ch.ch_src[i*ADDR_W +: ADDR_W];
          dest_r[i] <= ch.ch_dest[i*ADDR_W +: ADDR_W];
          size_r[i] <= ch.ch_size[i*ADDR_W +: ADDR_W];
        end
      end
      case (state)
        IDLE: if (grant_valid && !eng.dma_busy) begin
          active_ch    <= grant_idx;
          eng.dma_src  <= src_r[grant_idx];
          eng.dma_dest <= dest_r[grant_idx];
          eng.dma_size <= size_r[grant_idx];
          err_flag     <= 1'b0;
          state        <= (size_r[grant_idx] == '0) ? COMPLETE : ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (eng.dma_done) begin
            state <= COMPLETE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_flag <= 1'b1;
            state    <= COMPLETE;
          end
        end
        COMPLETE: begin
          pend[active_ch] <= 1'b0;
          last_grant      <= active_ch;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign act_oh        = NUM_CH'(1) << active_ch;
  assign ch.ch_ack     = ack_q;
  assign ch.ch_done    = (state == COMPLETE && !err_flag) ? act_oh : '0;
  assign ch.ch_err     = (state == COMPLETE &&  err_flag) ? act_oh : '0;
  assign eng.dma_start = (state == ISSUE);
  assign sched_busy    = (state != IDLE);

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Randomised + directed bench: descriptor queues feed a round-robin reference model and a completion scoreboard.
`timescale 1ns/1ps
module tb_dma_channel_scheduler;
  localparam int NUM_CH = 4, ADDR_W = 32, TIMEOUT_CYC = 8, CH_W = 2;

  typedef struct packed { logic [31:0] src, dest, size; } desc_t;
  typedef struct packed { int ch; bit err; bit zero; int gcyc; desc_t d; } exp_t;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_ch_if  #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) ch();
  dma_eng_if #(.ADDR_W(ADDR_W)) eng();
  logic            sched_busy;
  logic [CH_W-1:0] active_ch;

  dma_channel_scheduler #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .ch(ch), .eng(eng), .sched_busy(sched_busy), .active_ch(active_ch)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine model: src[31] marks a descriptor the engine never finishes; otherwise done after 1..3 cycles.
  logic eng_busy = 1'b0, eng_done = 1'b0, force_busy = 1'b0;
  assign eng.dma_busy = eng_busy | force_busy;
  assign eng.dma_done = eng_done;
  initial forever begin
    @(posedge clk); #1;
    if (eng.dma_start) begin
      eng_busy = 1'b1;
      if (eng.dma_src[31]) begin
        repeat (TIMEOUT_CYC + 4) @(posedge clk);
        #1 eng_busy = 1'b0;
      end else begin
        repeat (1 + int'(eng.dma_size % 3)) @(posedge clk);
        #1 eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0; eng_busy = 1'b0;
      end
    end
  end

  // Reference state
  desc_t posted_q[NUM_CH][$];
  desc_t desc_m[NUM_CH];
  exp_t  exp_q[$];
  int    grant_log[$];
  logic [NUM_CH-1:0] pend_m = '0, pend_prev = '0;
  int    last_m = NUM_CH - 1, done_cyc = -100;
  bit    busy_prev = 0, dbusy_prev = 0, rst_s = 0;
  always @(posedge clk) rst_s <= reset_n;

  function automatic int rr_pick(input logic [NUM_CH-1:0] p, input int last);
    for (int k = 1; k <= NUM_CH; k++) if (p[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!rst_s) begin
      chk("reset_ctl", {ch.ch_ack, ch.ch_done, ch.ch_err, eng.dma_start, sched_busy, active_ch}, 0);
      chk("reset_desc", eng.dma_src | eng.dma_dest | eng.dma_size, 0);
      pend_m = '0; pend_prev = '0; last_m = NUM_CH - 1; exp_q.delete();
      busy_prev = 0; dbusy_prev = eng.dma_busy;
    end else begin
      if (eng.dma_done) done_cyc = cyc;
      if (sched_busy && !busy_prev) begin
        int w;
        exp_t e;
        w = rr_pick(pend_prev, last_m);
        chk("grant_had_pending", w >= 0, 1);
        chk("grant_engine_idle", dbusy_prev, 0);
        chk("grant_ch", active_ch, w);
        grant_log.push_back(int'(active_ch));
        if (w >= 0) begin
          e.ch = w; e.d = desc_m[w]; e.zero = (desc_m[w].size == 0);
          e.err = !e.zero && desc_m[w].src[31]; e.gcyc = cyc;
          chk("dma_src", eng.dma_src, e.d.src);
          chk("dma_dest", eng.dma_dest, e.d.dest);
          chk("dma_size", eng.dma_size, e.d.size);
          chk("start_at_grant", eng.dma_start, !e.zero);
          exp_q.push_back(e);
        end
      end else if (eng.dma_start) begin
        chk("start_outside_grant", eng.dma_start, 0);
      end
      for (int i = 0; i < NUM_CH; i++) if (ch.ch_ack[i]) begin
        if (posted_q[i].size() == 0) chk("unexpected_ack", i, -1);
        else begin
          desc_m[i] = posted_q[i].pop_front();
          chk("ack_while_pending", pend_m[i], 0);
          pend_m[i] = 1'b1;
        end
      end
      if (ch.ch_done != 0 || ch.ch_err != 0) begin
        if (exp_q.size() == 0) chk("unexpected_completion", {ch.ch_done, ch.ch_err}, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_vec", ch.ch_done, e.err ? 0 : (1 << e.ch));
          chk("err_vec", ch.ch_err, e.err ? (1 << e.ch) : 0);
          chk("desc_held", {eng.dma_src, eng.dma_dest, eng.dma_size}, e.d);
          if (e.zero)     chk("zero_size_latency", cyc - e.gcyc, 0);
          else if (e.err) chk("timeout_latency", cyc - e.gcyc, TIMEOUT_CYC + 1);
          else            chk("done_latency", cyc - done_cyc, 1);
          pend_m[e.ch] = 1'b0;
          last_m = e.ch;
        end
      end
      busy_prev = sched_busy; dbusy_prev = eng.dma_busy;
    end
    pend_prev = pend_m;
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) if (ch.ch_req[i] && ch.ch_ack[i]) ch.ch_req[i] = 1'b0;
  endtask

  task automatic post(input int i, input desc_t d);
    if (!ch.ch_req[i]) begin
      ch.ch_src[i*ADDR_W +: ADDR_W]  = d.src;
      ch.ch_dest[i*ADDR_W +: ADDR_W] = d.dest;
      ch.ch_size[i*ADDR_W +: ADDR_W] = d.size;
      ch.ch_req[i] = 1'b1;
      posted_q[i].push_back(d);
    end
  endtask

  function automatic bit all_quiet();
    int n;
    n = 0;
    for (int i = 0; i < NUM_CH; i++) n += posted_q[i].size();
    return ch.ch_req == 0 && !sched_busy && exp_q.size() == 0 && pend_m == 0 && n == 0;
  endfunction

  task automatic drain(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      ok = all_quiet();
    end
    chk(nm, ok, 1);
  endtask

  task automatic check_log(input string nm, input int exp[$]);
    chk({nm, "_count"}, grant_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < grant_log.size(); k++) chk(nm, grant_log[k], exp[k]);
  endtask

  initial begin
    int t_ack, t_st, t_dn, t_idle, t;
    bit found, saw_start;
    ch.ch_req = '0; ch.ch_src = '0; ch.ch_dest = '0; ch.ch_size = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Round-robin from reset, then ch0/ch2 re-request while ch3 owns the engine.
    grant_log.delete();
    for (int i = 0; i < NUM_CH; i++) post(i, '{32'h100 * (i + 1), 32'h900 + i, 32'd4 + i});
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      found = sched_busy && active_ch == 2'd3;
    end
    chk("rr_reach_ch3", found, 1);
    post(0, '{32'h5000, 32'h6000, 32'd7});
    post(2, '{32'h5200, 32'h6200, 32'd9});
    drain("rr_drain", 400);
    check_log("rr_order", '{0, 1, 2, 3, 0, 2});

    // Single channel latency with a 2-cycle engine (size 16).
    post(0, '{32'h1000, 32'h2000, 32'd16});
    t_ack = -1; t_st = -1; t_dn = -1; t_idle = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ch.ch_ack[0] && t_ack < 0) t_ack = k;
      if (eng.dma_start && t_st < 0) t_st = k;
      if (ch.ch_done[0] && t_dn < 0) t_dn = k;
      if (!sched_busy && t_dn >= 0 && t_idle < 0) t_idle = k;
    end
    chk("lat_ack", t_ack, 1);
    chk("lat_start", t_st, 2);
    chk("lat_done", t_dn, 5);
    chk("lat_idle", t_idle, 6);
    drain("single_drain", 50);

    // Zero-size descriptor, then a hung transfer followed by a normal one.
    post(1, '{32'h3000, 32'h4000, 32'd0});
    drain("zero_drain", 50);
    post(2, '{32'h8000_2000, 32'h7000, 32'd32});
    post(3, '{32'h0000_3300, 32'h7300, 32'd5});
    drain("timeout_drain", 200);

    // Reset while WAITing on a hung transfer; ch0 must win first afterwards.
    post(0, '{32'h8000_0100, 32'h7100, 32'd8});
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      found = eng.dma_start;
    end
    chk("reset_test_start", found, 1);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    grant_log.delete();
    post(3, '{32'h0000_0a00, 32'h0b00, 32'd3});
    post(0, '{32'h0000_0c00, 32'h0d00, 32'd6});
    drain("post_reset_drain", 200);
    check_log("post_reset_order", '{0, 3});

    // Engine held busy: no start until released, start one cycle after busy falls.
    force_busy = 1'b1;
    post(2, '{32'h0000_2222, 32'h3333, 32'd11});
    saw_start = 0;
    repeat (12) begin
      tick();
      saw_start |= eng.dma_start;
    end
    chk("busy_no_start", saw_start, 0);
    force_busy = 1'b0;
    t = -1;
    for (int k = 1; k <= 20 && t < 0; k++) begin
      tick();
      if (eng.dma_start) t = k;
    end
    chk("busy_release_start", t, 1);
    drain("busy_drain", 100);

    // Random traffic against the reference model.
    for (int n = 0; n < 2500; n++) begin
      tick();
      force_busy = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) begin
        desc_t d;
        d.src  = $urandom & 32'h7fff_ffff;
        if ($urandom_range(0, 7) == 0) d.src[31] = 1'b1;
        d.dest = $urandom;
        d.size = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
        post(int'($urandom_range(0, NUM_CH - 1)), d);
      end
    end
    force_busy = 1'b0;
    drain("random_drain", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
